// File: rtl/est_dr_fifo_sync.sv
// Clocked FIFO with dual-rail 4-phase handshakes on both sides, buffering DEPTH tokens
// and fanning its output out to N_CONS consumers whose acknowledges are joined.
module est_dr_fifo_sync #(
    parameter int               NBITS     = 4,
    parameter int               DEPTH     = 4,
    parameter int               N_CONS    = 2,
    parameter int               RST_TOKEN = 0,
    parameter logic [NBITS-1:0] RST_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2*NBITS-1:0]         data_in,
    output logic                       ack_ant,
    output logic [2*NBITS-1:0]         data_out,
    input  logic [N_CONS-1:0]          ack_next,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err_illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'((RST_TOKEN != 0) ? 1 : 0);
    localparam logic [PTR_W-1:0] WPTR_RST  = PTR_W'((RST_TOKEN != 0) ? 1 : 0);

    typedef enum logic {IN_WAIT_DATA, IN_WAIT_NULL} in_state_t;
    typedef enum logic {OUT_NULL, OUT_DATA}         out_state_t;

    in_state_t  in_state;
    out_state_t out_state;

    logic [2*NBITS-1:0] din_s1, din_s2;
    logic [N_CONS-1:0]  ack_s1, ack_s2;

    logic [NBITS-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count_q;

    logic               word_complete, word_null, word_illegal;
    logic [NBITS-1:0]   word_bits;
    logic               wr_en, pop_en, load_en;
    logic               acks_all_hi, acks_all_lo;

    function automatic logic [2*NBITS-1:0] encode(input logic [NBITS-1:0] value);
        logic [2*NBITS-1:0] rails;
        rails = '0;
        for (int i = 0; i < NBITS; i++) begin
            rails[2*i+1] = value[i];
            rails[2*i]   = ~value[i];
        end
        return rails;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_s1 <= '0;
            din_s2 <= '0;
            ack_s1 <= '0;
            ack_s2 <= '0;
        end else begin
            din_s1 <= data_in;
            din_s2 <= din_s1;
            ack_s1 <= ack_next;
            ack_s2 <= ack_s1;
        end
    end

    // An 11 pair makes its rails equal, so it can never be counted as complete.
    always_comb begin
        word_complete = 1'b1;
        word_null     = 1'b1;
        word_illegal  = 1'b0;
        word_bits     = '0;
        for (int i = 0; i < NBITS; i++) begin
            word_bits[i] = din_s2[2*i+1];
            if (din_s2[2*i+1] == din_s2[2*i]) word_complete = 1'b0;
            if (din_s2[2*i+1] | din_s2[2*i])  word_null     = 1'b0;
            if (din_s2[2*i+1] & din_s2[2*i])  word_illegal  = 1'b1;
        end
    end

    assign acks_all_hi = &ack_s2;
    assign acks_all_lo = ~|ack_s2;

    assign wr_en   = (in_state == IN_WAIT_DATA) && word_complete && (count_q < FULL_CNT);
    assign pop_en  = (out_state == OUT_DATA) && acks_all_hi;
    assign load_en = (out_state == OUT_NULL) && (count_q != '0) && acks_all_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_illegal <= 1'b0;
        end else if (word_illegal) begin
            err_illegal <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state <= IN_WAIT_DATA;
            ack_ant  <= 1'b0;
        end else begin
            case (in_state)
                IN_WAIT_DATA: begin
                    if (wr_en) begin
                        ack_ant  <= 1'b1;
                        in_state <= IN_WAIT_NULL;
                    end
                end
                IN_WAIT_NULL: begin
                    if (word_null) begin
                        ack_ant  <= 1'b0;
                        in_state <= IN_WAIT_DATA;
                    end
                end
                default: begin
                    ack_ant  <= 1'b0;
                    in_state <= IN_WAIT_DATA;
                end
            endcase
        end
    end

    // Slot 0 carries the preloaded token when the reset-token mode is enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= WPTR_RST;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i == 0 && RST_TOKEN != 0) ? RST_VALUE : '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= word_bits;
            wr_ptr      <= wr_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_state <= OUT_NULL;
            data_out  <= '0;
            rd_ptr    <= '0;
        end else begin
            case (out_state)
                OUT_NULL: begin
                    if (load_en) begin
                        data_out  <= encode(mem[rd_ptr]);
                        out_state <= OUT_DATA;
                    end
                end
                OUT_DATA: begin
                    if (pop_en) begin
                        data_out  <= '0;
                        rd_ptr    <= rd_ptr + PTR_W'(1);
                        out_state <= OUT_NULL;
                    end
                end
                default: begin
                    data_out  <= '0;
                    out_state <= OUT_NULL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= CNT_RST;
        end else begin
            case ({wr_en, pop_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // The occupancy register may hold the preload value during reset, so the port is masked.
    assign count = rst ? '0 : count_q;

endmodule

// File: tb/tb_est_dr_fifo_sync.sv
// Directed bench for est_dr_fifo_sync: one instance with an empty reset, one with a
// preloaded reset token.
module tb_est_dr_fifo_sync;

    logic       clk;
    logic       rst0, rst1;
    logic [7:0] data_in0, data_in1;
    logic [1:0] ack_next0, ack_next1;
    logic       ack_ant0, ack_ant1;
    logic [7:0] data_out0, data_out1;
    logic [2:0] count0, count1;
    logic       err0, err1;

    int tests_run;
    int tests_failed;

    est_dr_fifo_sync #(.NBITS(4), .DEPTH(4), .N_CONS(2), .RST_TOKEN(0), .RST_VALUE(4'h0)) dut0 (
        .clk(clk), .rst(rst0), .data_in(data_in0), .ack_ant(ack_ant0),
        .data_out(data_out0), .ack_next(ack_next0), .count(count0), .err_illegal(err0)
    );

    est_dr_fifo_sync #(.NBITS(4), .DEPTH(4), .N_CONS(2), .RST_TOKEN(1), .RST_VALUE(4'h5)) dut1 (
        .clk(clk), .rst(rst1), .data_in(data_in1), .ack_ant(ack_ant1),
        .data_out(data_out1), .ack_next(ack_next1), .count(count1), .err_illegal(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-rail code of a 4-bit value: a 1 is 10, a 0 is 01, MSB pair first.
    function automatic logic [7:0] enc(input logic [3:0] v);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) begin
            r[2*i+1] = v[i];
            r[2*i]   = ~v[i];
        end
        return r;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_token(input logic [7:0] word);
        data_in0 = word;
        step(3);
        data_in0 = 8'h00;
        step(3);
    endtask

    task automatic pop_token();
        ack_next0 = 2'b11;
        step(3);
        ack_next0 = 2'b00;
        step(3);
    endtask

    task automatic test_reset();
        step(3);
        tests_run++; if (count0 !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", count0); end
        tests_run++; if (data_out0 !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_data_out: got %h expected 00", data_out0); end
        tests_run++; if (ack_ant0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ack_ant: got %b expected 0", ack_ant0); end
        tests_run++; if (err0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b expected 0", err0); end
        rst0 = 1'b0;
        #1;
        tests_run++; if (count0 !== 3'd0) begin tests_failed++; $display("[TB] FAIL release_count: got %0d expected 0", count0); end
        step(1);
    endtask

    task automatic test_single();
        data_in0 = 8'b10_01_10_01;
        step(2);
        tests_run++; if (ack_ant0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_ack_early: got %b expected 0", ack_ant0); end
        step(1);
        tests_run++; if (ack_ant0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_ack: got %b expected 1", ack_ant0); end
        tests_run++; if (count0 !== 3'd1) begin tests_failed++; $display("[TB] FAIL single_count: got %0d expected 1", count0); end
        step(1);
        tests_run++; if (data_out0 !== 8'b10011001) begin tests_failed++; $display("[TB] FAIL single_data_out: got %b expected 10011001", data_out0); end
        data_in0  = 8'h00;
        ack_next0 = 2'b11;
        step(3);
        tests_run++; if (ack_ant0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_ack_fall: got %b expected 0", ack_ant0); end
        tests_run++; if (data_out0 !== 8'h00) begin tests_failed++; $display("[TB] FAIL single_pop_null: got %h expected 00", data_out0); end
        tests_run++; if (count0 !== 3'd0) begin tests_failed++; $display("[TB] FAIL single_pop_count: got %0d expected 0", count0); end
        ack_next0 = 2'b00;
        step(3);
    endtask

    task automatic test_fill();
        send_token(8'h56);
        send_token(8'h59);
        send_token(8'h5A);
        send_token(8'h65);
        tests_run++; if (count0 !== 3'd4) begin tests_failed++; $display("[TB] FAIL fill_count: got %0d expected 4", count0); end
        tests_run++; if (data_out0 !== 8'h56) begin tests_failed++; $display("[TB] FAIL fill_head: got %h expected 56", data_out0); end
        data_in0 = 8'h66;
        step(5);
        tests_run++; if (ack_ant0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_full_noack: got %b expected 0", ack_ant0); end
        tests_run++; if (count0 !== 3'd4) begin tests_failed++; $display("[TB] FAIL fill_full_count: got %0d expected 4", count0); end
        ack_next0 = 2'b11;
        step(3);
        tests_run++; if (count0 !== 3'd3) begin tests_failed++; $display("[TB] FAIL fill_pop_count: got %0d expected 3", count0); end
        tests_run++; if (data_out0 !== 8'h00) begin tests_failed++; $display("[TB] FAIL fill_pop_null: got %h expected 00", data_out0); end
        tests_run++; if (ack_ant0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_pop_noack: got %b expected 0", ack_ant0); end
        step(1);
        tests_run++; if (ack_ant0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL fill_late_ack: got %b expected 1", ack_ant0); end
        tests_run++; if (count0 !== 3'd4) begin tests_failed++; $display("[TB] FAIL fill_refill_count: got %0d expected 4", count0); end
        ack_next0 = 2'b00;
        data_in0  = 8'h00;
        step(3);
        tests_run++; if (data_out0 !== 8'h59) begin tests_failed++; $display("[TB] FAIL fill_next_head: got %h expected 59", data_out0); end
        tests_run++; if (ack_ant0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_ack_fall: got %b expected 0", ack_ant0); end
    endtask

    task automatic test_join();
        ack_next0 = 2'b01;
        step(5);
        tests_run++; if (data_out0 !== 8'h59) begin tests_failed++; $display("[TB] FAIL join_mixed_hold: got %h expected 59", data_out0); end
        tests_run++; if (count0 !== 3'd4) begin tests_failed++; $display("[TB] FAIL join_mixed_count: got %0d expected 4", count0); end
        ack_next0 = 2'b11;
        step(3);
        tests_run++; if (data_out0 !== 8'h00) begin tests_failed++; $display("[TB] FAIL join_pop_null: got %h expected 00", data_out0); end
        tests_run++; if (count0 !== 3'd3) begin tests_failed++; $display("[TB] FAIL join_pop_count: got %0d expected 3", count0); end
        step(3);
        tests_run++; if (data_out0 !== 8'h00) begin tests_failed++; $display("[TB] FAIL join_wait_acks_low: got %h expected 00", data_out0); end
        ack_next0 = 2'b00;
        step(2);
        tests_run++; if (data_out0 !== 8'h00) begin tests_failed++; $display("[TB] FAIL join_sync_delay: got %h expected 00", data_out0); end
        step(1);
        tests_run++; if (data_out0 !== 8'h5A) begin tests_failed++; $display("[TB] FAIL join_next_token: got %h expected 5A", data_out0); end
        pop_token();
        pop_token();
        pop_token();
        tests_run++; if (count0 !== 3'd0) begin tests_failed++; $display("[TB] FAIL join_drain_count: got %0d expected 0", count0); end
        tests_run++; if (data_out0 !== 8'h00) begin tests_failed++; $display("[TB] FAIL join_drain_null: got %h expected 00", data_out0); end
    endtask

    // Reactive producer and consumer; every rising data word must be the next in sequence.
    task automatic test_wrap();
        int         sent;
        int         received;
        logic [7:0] prev_out;
        sent     = 0;
        received = 0;
        prev_out = data_out0;
        for (int c = 0; c < 400; c++) begin
            if (data_out0 !== 8'h00 && prev_out === 8'h00) begin
                tests_run++;
                if (data_out0 !== enc(4'(received))) begin
                    tests_failed++;
                    $display("[TB] FAIL wrap_order[%0d]: got %h expected %h", received, data_out0, enc(4'(received)));
                end
                received++;
            end
            prev_out  = data_out0;
            ack_next0 = (data_out0 != 8'h00) ? 2'b11 : 2'b00;
            if (ack_ant0 && data_in0 != 8'h00) begin
                data_in0 = 8'h00;
                sent++;
            end else if (!ack_ant0 && data_in0 == 8'h00 && sent < 10) begin
                data_in0 = enc(4'(sent));
            end
            step(1);
        end
        tests_run++; if (received != 10) begin tests_failed++; $display("[TB] FAIL wrap_received: got %0d expected 10", received); end
        tests_run++; if (count0 !== 3'd0) begin tests_failed++; $display("[TB] FAIL wrap_final_count: got %0d expected 0", count0); end
        tests_run++; if (data_out0 !== 8'h00) begin tests_failed++; $display("[TB] FAIL wrap_final_null: got %h expected 00", data_out0); end
    endtask

    task automatic test_illegal();
        data_in0 = 8'b01_01_01_11;
        step(2);
        tests_run++; if (err0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL illegal_early: got %b expected 0", err0); end
        step(1);
        tests_run++; if (err0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL illegal_flag: got %b expected 1", err0); end
        tests_run++; if (ack_ant0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL illegal_noack: got %b expected 0", ack_ant0); end
        tests_run++; if (count0 !== 3'd0) begin tests_failed++; $display("[TB] FAIL illegal_nowrite: got %0d expected 0", count0); end
        data_in0 = 8'h00;
        step(3);
        tests_run++; if (err0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL illegal_sticky: got %b expected 1", err0); end
        tests_run++; if (count0 !== 3'd0) begin tests_failed++; $display("[TB] FAIL illegal_after_null_count: got %0d expected 0", count0); end
        rst0 = 1'b1;
        #1;
        tests_run++; if (err0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL illegal_cleared: got %b expected 0", err0); end
        step(2);
        rst0 = 1'b0;
        step(1);
    endtask

    task automatic test_rst_token();
        tests_run++; if (count1 !== 3'd0) begin tests_failed++; $display("[TB] FAIL tok_reset_count: got %0d expected 0", count1); end
        tests_run++; if (data_out1 !== 8'h00) begin tests_failed++; $display("[TB] FAIL tok_reset_data_out: got %h expected 00", data_out1); end
        rst1 = 1'b0;
        #1;
        tests_run++; if (count1 !== 3'd1) begin tests_failed++; $display("[TB] FAIL tok_release_count: got %0d expected 1", count1); end
        step(1);
        tests_run++; if (data_out1 !== 8'b01100110) begin tests_failed++; $display("[TB] FAIL tok_data_out: got %b expected 01100110", data_out1); end
        data_in1 = 8'h5A;
        step(3);
        tests_run++; if (ack_ant1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL tok_second_ack: got %b expected 1", ack_ant1); end
        tests_run++; if (count1 !== 3'd2) begin tests_failed++; $display("[TB] FAIL tok_second_count: got %0d expected 2", count1); end
        rst1 = 1'b1;
        #1;
        tests_run++; if (data_out1 !== 8'h00) begin tests_failed++; $display("[TB] FAIL tok_midrst_data_out: got %h expected 00", data_out1); end
        tests_run++; if (ack_ant1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL tok_midrst_ack: got %b expected 0", ack_ant1); end
        tests_run++; if (count1 !== 3'd0) begin tests_failed++; $display("[TB] FAIL tok_midrst_count: got %0d expected 0", count1); end
        data_in1 = 8'h00;
        step(2);
        rst1 = 1'b0;
        #1;
        tests_run++; if (count1 !== 3'd1) begin tests_failed++; $display("[TB] FAIL tok_rerelease_count: got %0d expected 1", count1); end
        step(1);
        tests_run++; if (data_out1 !== 8'h66) begin tests_failed++; $display("[TB] FAIL tok_rerelease_data_out: got %h expected 66", data_out1); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst0      = 1'b1;
        rst1      = 1'b1;
        data_in0  = 8'h00;
        data_in1  = 8'h00;
        ack_next0 = 2'b00;
        ack_next1 = 2'b00;
        test_reset();
        test_single();
        test_fill();
        test_join();
        test_wrap();
        test_illegal();
        test_rst_token();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
